// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture_pkg
//  Description : Shared constants for the PWM capture block: default widths,
//                stuck-input timeout, glitch-filter length and FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

    localparam int C_CNT_W_DEF   = 8;
    localparam int C_TIMEOUT_DEF = 511;
    localparam int C_FILT_LEN    = 3;

    // Capture FSM encoding
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_HIGH = 2'd1;
    localparam logic [1:0] C_ST_LOW  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pwm_in_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_in_sync
//  Description : Two-flop synchronizer for the raw PWM input, optional glitch
//                filter (macro PWM_CAPTURE_FILTER_EN), and registered edge
//                detect. s, rise and fall change on the same clock edge, so a
//                rise/fall pulse always coincides with the first cycle of the
//                new level of s.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_in_sync
    import pwm_capture_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_s;
    logic r_rise;
    logic r_fall;
    logic w_s_next;

    // Metastability guard for the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int              C_FCNT_W   = $clog2(C_FILT_LEN);
    localparam logic [C_FCNT_W-1:0] C_FCNT_MAX = C_FCNT_W'(C_FILT_LEN - 1);

    logic [C_FCNT_W-1:0] r_fcnt;

    // Count consecutive cycles where the synced level disagrees with s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if ((r_sync2 != r_s) && (r_fcnt != C_FCNT_MAX)) begin
            r_fcnt <= r_fcnt + 1'b1;
        end else begin
            r_fcnt <= '0;
        end
    end

    // Accept the new level on the third consecutive disagreeing sample
    assign w_s_next = ((r_sync2 != r_s) && (r_fcnt == C_FCNT_MAX)) ? r_sync2 : r_s;
`else
    assign w_s_next = r_sync2;
`endif

    // Level register doubles as the previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s    <= w_s_next;
            r_rise <= w_s_next & ~r_s;
            r_fall <= ~w_s_next & r_s;
        end
    end

    assign s    = r_s;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures an incoming PWM waveform: high time and period of
//                the last complete period in clk cycles, plus stuck-input
//                detection. Optional glitch filter enabled by defining
//                PWM_CAPTURE_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = C_CNT_W_DEF,
    parameter int TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W:0]   high_o,
    output logic [CNT_W+1:0] period_o,
    output logic             valid_o,
    output logic             stuck_o,
    output logic             stuck_level_o
);

    localparam logic [CNT_W:0] C_TO    = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W:0] C_TO_M1 = (CNT_W + 1)'(TIMEOUT - 1);

    logic           w_s;
    logic           w_rise;
    logic           w_fall;
    logic           w_edge;
    logic           w_timeout;
    logic [1:0]     r_state;
    logic [CNT_W:0] r_hc;
    logic [CNT_W:0] r_lc;
    logic [CNT_W:0] r_ec;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (w_s),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_edge    = w_rise | w_fall;
    // Fires on the cycle ec would reach TIMEOUT; an edge in that cycle wins
    assign w_timeout = !w_edge && (r_ec == C_TO_M1);

    // Cycles since last edge; saturates at TIMEOUT so the timeout fires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ec <= '0;
        end else if (!en || w_edge) begin
            r_ec <= '0;
        end else if (r_ec != C_TO) begin
            r_ec <= r_ec + 1'b1;
        end
    end

    // Capture FSM, high/low counters and published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= C_ST_IDLE;
            r_hc          <= '0;
            r_lc          <= '0;
            high_o        <= '0;
            period_o      <= '0;
            valid_o       <= 1'b0;
            stuck_o       <= 1'b0;
            stuck_level_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (!en) begin
                r_state <= C_ST_IDLE;
                r_hc    <= '0;
                r_lc    <= '0;
            end else if (w_timeout) begin
                r_state       <= C_ST_IDLE;
                r_hc          <= '0;
                r_lc          <= '0;
                high_o        <= '0;
                period_o      <= '0;
                stuck_o       <= 1'b1;
                stuck_level_o <= w_s;
                valid_o       <= 1'b1;
            end else begin
                case (r_state)
                    C_ST_IDLE: begin
                        // No report for the partial period before the first rise
                        if (w_rise) begin
                            r_state <= C_ST_HIGH;
                            r_hc    <= (CNT_W + 1)'(1);
                        end
                    end
                    C_ST_HIGH: begin
                        if (w_fall) begin
                            r_state <= C_ST_LOW;
                            r_lc    <= (CNT_W + 1)'(1);
                        end else begin
                            r_hc <= r_hc + 1'b1;
                        end
                    end
                    C_ST_LOW: begin
                        if (w_rise) begin
                            high_o   <= r_hc;
                            period_o <= (CNT_W + 2)'(r_hc) + (CNT_W + 2)'(r_lc);
                            stuck_o  <= 1'b0;
                            valid_o  <= 1'b1;
                            r_state  <= C_ST_HIGH;
                            r_hc     <= (CNT_W + 1)'(1);
                        end else begin
                            r_lc <= r_lc + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= C_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
